md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. It executes mult/multu/div/divu by borrowing the shared 32-bit add/sub ALU for 36 consecutive cycles, holds the HI/LO registers, and serves mthi/mtlo writes. While it owns the ALU it asserts busy; the hazard unit stalls any instruction that needs md_sequencer or the ALU.

---
 rtl/md_sequencer_pkg.sv | 31 +++
 rtl/md_datapath.sv | 64 ++++++
 rtl/md_sequencer.sv | 154 +++++++++++++++
 tb/tb_md_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - shared ALU op codes, md_op encodings and state types
package md_sequencer_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b0001;
  localparam logic [3:0] ALUOP_OR  = 4'b0010;
  localparam logic [3:0] ALUOP_LUI = 4'b0011;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_ITER,
    ST_FIX_LO,
    ST_FIX_HI
  } md_state_e;

  // Datapath command: load magnitude of rs, load magnitude of rt, iterate
  typedef enum logic [1:0] {
    DP_HOLD,
    DP_LOAD_A,
    DP_LOAD_B,
    DP_STEP
  } dp_cmd_e;

endpackage

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - accumulator/remainder/quotient registers and iteration step
module md_datapath
  import md_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  dp_cmd_e     cmd,
  input  logic        is_div,
  input  logic [31:0] mag,
  input  logic [31:0] alu_c,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo,
  output logic [3:0]  step_op,
  output logic [31:0] step_a,
  output logic [31:0] step_b
);

  // acc_hi doubles as the remainder, acc_lo as multiplier/quotient,
  // opnd as multiplicand/divisor (multiplication is commutative, so
  // rs magnitude sits in acc_lo for both op classes)
  logic [31:0] opnd;
  logic [32:0] t;
  logic        ge;
  logic        carry;
  logic [31:0] sum;

  // Shift-add and restoring-divide step terms
  always_comb begin
    t       = {acc_hi, acc_lo[31]};
    ge      = (t >= {1'b0, opnd});
    sum     = acc_lo[0] ? alu_c : acc_hi;
    carry   = acc_lo[0] & (alu_c < acc_hi);
    step_op = is_div ? ALUOP_SUB : ALUOP_ADD;
    step_a  = is_div ? t[31:0] : acc_hi;
    step_b  = opnd;
  end

  // Register load and per-iteration update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else begin
      case (cmd)
        DP_LOAD_A: acc_lo <= mag;
        DP_LOAD_B: begin
          opnd   <= mag;
          acc_hi <= '0;
        end
        DP_STEP: begin
          if (is_div) begin
            acc_hi <= ge ? alu_c : t[31:0];
            acc_lo <= {acc_lo[30:0], ge};
          end else begin
            {acc_hi, acc_lo} <= {carry, sum, acc_lo[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle mult/div sequencer borrowing the shared ALU
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        alu_own,
  output logic [3:0]  md_alu_op,
  output logic [31:0] md_alu_a,
  output logic [31:0] md_alu_b,
  input  logic [31:0] alu_c,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  md_state_e   state, state_next;
  logic [CW-1:0] cnt;
  logic        op_div, op_signed, neg_q, neg_r, div0;
  logic [31:0] rs_lat, rt_lat, lo_tmp;
  logic [31:0] mag, lo_fix, hi_fix;
  logic [31:0] acc_hi, acc_lo;
  logic [3:0]  step_op;
  logic [31:0] step_a, step_b;
  dp_cmd_e     dp_cmd;

  md_datapath u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (dp_cmd),
    .is_div  (op_div),
    .mag     (mag),
    .alu_c   (alu_c),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .step_op (step_op),
    .step_a  (step_a),
    .step_b  (step_b)
  );

  assign busy    = (state != ST_IDLE);
  assign alu_own = busy;

  // Next state and ALU operand decode; ALU inputs depend only on registers
  always_comb begin
    state_next = state;
    md_alu_op  = ALUOP_ADD;
    md_alu_a   = '0;
    md_alu_b   = '0;
    dp_cmd     = DP_HOLD;
    mag        = '0;
    lo_fix     = '0;
    hi_fix     = '0;
    case (state)
      ST_IDLE: if (start) state_next = ST_NEG_A;
      ST_NEG_A: begin
        md_alu_op  = ALUOP_SUB;
        md_alu_b   = rs_lat;
        mag        = (op_signed && rs_lat[31]) ? alu_c : rs_lat;
        dp_cmd     = DP_LOAD_A;
        state_next = ST_NEG_B;
      end
      ST_NEG_B: begin
        md_alu_op  = ALUOP_SUB;
        md_alu_b   = rt_lat;
        mag        = (op_signed && rt_lat[31]) ? alu_c : rt_lat;
        dp_cmd     = DP_LOAD_B;
        state_next = ST_ITER;
      end
      ST_ITER: begin
        md_alu_op = step_op;
        md_alu_a  = step_a;
        md_alu_b  = step_b;
        dp_cmd    = DP_STEP;
        if (cnt == CW'(ITER - 1)) state_next = ST_FIX_LO;
      end
      ST_FIX_LO: begin
        md_alu_op  = ALUOP_SUB;
        md_alu_b   = acc_lo;
        lo_fix     = div0 ? 32'hFFFF_FFFF : (neg_q ? alu_c : acc_lo);
        state_next = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        if (op_div) begin
          md_alu_op = ALUOP_SUB;
          md_alu_b  = acc_hi;
          hi_fix    = div0 ? rs_lat : (neg_r ? alu_c : acc_hi);
        end else begin
          md_alu_op = ALUOP_ADD;
          md_alu_a  = ~acc_hi;
          md_alu_b  = {31'd0, (acc_lo == 32'd0)};
          hi_fix    = neg_q ? alu_c : acc_hi;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, launch latches, counter and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      rs_lat    <= '0;
      rt_lat    <= '0;
      lo_tmp    <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == ST_FIX_HI);
      cnt   <= (state == ST_ITER) ? cnt + 1'b1 : '0;
      if (state == ST_IDLE) begin
        if (start) begin
          rs_lat    <= rs_val;
          rt_lat    <= rt_val;
          op_div    <= md_op[1];
          op_signed <= ~md_op[0];
          neg_q     <= ~md_op[0] & (rs_val[31] ^ rt_val[31]);
          neg_r     <= ~md_op[0] & rs_val[31];
          div0      <= md_op[1] & (rt_val == 32'd0);
        end else begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
        end
      end
      if (state == ST_FIX_LO) lo_tmp <= lo_fix;
      if (state == ST_FIX_HI) begin
        hi <= hi_fix;
        lo <= lo_tmp;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed self-checking bench for md_sequencer
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        alu_own;
  logic [3:0]  md_alu_op;
  logic [31:0] md_alu_a, md_alu_b, alu_c;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_sequencer #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .alu_own   (alu_own),
    .md_alu_op (md_alu_op),
    .md_alu_a  (md_alu_a),
    .md_alu_b  (md_alu_b),
    .alu_c     (alu_c),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Shared EX-stage ALU model: add/sub only
  assign alu_c = (md_alu_op == 4'b0001) ? (md_alu_a - md_alu_b) : (md_alu_a + md_alu_b);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit inject);
    int nbusy = 0;
    int nown  = 0;
    logic [31:0] hi_prev = hi;
    logic [31:0] lo_prev = lo;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    while (busy === 1'b1 && nbusy < 60) begin
      nbusy++;
      if (alu_own === 1'b1) nown++;
      if (inject && nbusy == 5) begin mtlo = 1'b1; wdata = 32'h55; end
      if (inject && nbusy == 6) mtlo = 1'b0;
      if (nbusy == 36) begin
        chk({tag, " hi_hold"}, hi, hi_prev);
        chk({tag, " lo_hold"}, lo, lo_prev);
      end
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'd36);
    chk({tag, " own_cycles"}, 32'(nown), 32'd36);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst own", {31'd0, alu_own}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst aluop", {28'd0, md_alu_op}, 32'd0);
    chk("rst alua", md_alu_a, 32'd0);
    chk("rst alub", md_alu_b, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    tick();
    chk("done pulse width", {31'd0, done}, 32'd0);
    chk("idle alua", md_alu_a, 32'd0);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("mult min*2", 2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("divu max/10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0);

    tick();
    mthi = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h1234);
    chk("mthi lo kept", lo, 32'h1999_9999);

    run_op("mult mtlo ignored", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

    tick();
    start = 1'b1; md_op = 2'b01; rs_val = 32'd3; rt_val = 32'd5; mthi = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; mthi = 1'b0;
    chk("start beats mthi", hi, 32'd0);
    chk("start busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 36; i++) tick();
    chk("multu 3*5 lo", lo, 32'd15);
    chk("multu 3*5 hi", hi, 32'd0);

    tick();
    start = 1'b1; md_op = 2'b10; rs_val = 32'd1000; rt_val = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op("divu after rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
